pf_ddr_ca_lane_ctrl: RTL and testbench

Parametrised fabric-side controller for a bank of DDR address/command output lanes. It registers 4:1 command beats onto every lane's TX/OE slots and parks lanes between commands by holding the last driven level. It also runs a per-lane delay-line step engine that turns a requested tap code into LOAD/DIRECTION/MOVE pulses. It sits between the DDR sequencer and the per-pin IOD wrappers, one instance per address/command group.

---
 rtl/pf_ddr_ca_pkg.sv | 21 ++
 rtl/pf_ddr_dly_step_fsm.sv | 149 ++++++++++++++
 rtl/pf_ddr_ca_lane_ctrl.sv | 92 +++++++++
 tb/tb_pf_ddr_ca_lane_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pf_ddr_ca_pkg.sv
// Shared types and helpers for the DDR address/command lane controller.
package pf_ddr_ca_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_MOVE,
        ST_GAP,
        ST_DONE
    } eng_state_e;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Width of a lane index; a single-lane bank still needs one bit.
    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pf_ddr_dly_step_fsm.sv
// Delay-line step engine: walks one lane's IOD tap from its current value to
// a requested target with LOAD/DIRECTION/MOVE pulses, and keeps the tap table.
module pf_ddr_dly_step_fsm
    import pf_ddr_ca_pkg::*;
#(
    parameter int NUM_LANES = 15,
    parameter int TAP_W     = 8,
    parameter int LOAD_TAP  = 1,
    parameter int MOVE_GAP  = 3,
    parameter int LANE_W    = lane_idx_w(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cal_req,
    input  logic [LANE_W-1:0]    cal_lane,
    input  logic [TAP_W-1:0]     cal_tap,
    output logic                 cal_ack,
    output logic                 cal_err,
    output logic [TAP_W-1:0]     tap_rd,
    output logic [NUM_LANES-1:0] dl_load,
    output logic [NUM_LANES-1:0] dl_move,
    output logic [NUM_LANES-1:0] dl_dir,
    input  logic [NUM_LANES-1:0] dl_oor,
    output logic                 idle,
    output logic                 req_acc
);

    localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
    localparam logic [TAP_W-1:0] LOAD_TAP_V = TAP_W'(LOAD_TAP);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(MOVE_GAP - 1);

    eng_state_e           state_q, state_d;
    logic [LANE_W-1:0]    lane_q;
    logic [TAP_W-1:0]     tgt_q;
    logic                 err_q;
    logic [GAP_W-1:0]     gap_q;
    logic [NUM_LANES-1:0] known_q;
    logic [TAP_W-1:0]     tap_q [NUM_LANES];

    logic                 req_in_range, req_known, oor_hit, gap_last, step_inc;
    logic [TAP_W-1:0]     req_tap, cur_tap, step_tap;
    logic [NUM_LANES-1:0] lane_oh, req_oh;

    // Out-of-range lane numbers decode to an empty one-hot, so they can never
    // raise a pulse or read as known.
    assign req_in_range = {1'b0, cal_lane} < (LANE_W + 1)'(NUM_LANES);
    assign req_oh       = NUM_LANES'(1) << cal_lane;
    assign req_known    = |(known_q & req_oh);
    assign req_tap      = req_in_range ? tap_q[cal_lane] : '0;
    assign lane_oh      = NUM_LANES'(1) << lane_q;
    assign cur_tap      = tap_q[lane_q];
    // Direction never flips mid-request: the walk stops the moment cur == tgt.
    assign step_inc     = (tgt_q > cur_tap) ? DIR_INC : DIR_DEC;
    assign step_tap     = (step_inc == DIR_INC) ? cur_tap + TAP_W'(1) : cur_tap - TAP_W'(1);
    assign gap_last     = (gap_q == GAP_LAST);
    assign oor_hit      = |(dl_oor & lane_oh);
    assign idle         = (state_q == ST_IDLE);
    assign req_acc      = idle & cal_req;
    assign tap_rd       = req_tap;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cal_req) begin
                    if (!req_in_range)          state_d = ST_DONE;
                    else if (!req_known)        state_d = ST_LOAD;
                    else if (req_tap == cal_tap) state_d = ST_DONE;
                    else                        state_d = ST_SETUP;
                end
            end
            ST_LOAD:  state_d = (LOAD_TAP_V == tgt_q) ? ST_DONE : ST_SETUP;
            ST_SETUP: state_d = ST_MOVE;
            ST_MOVE:  state_d = ST_GAP;
            ST_GAP: begin
                if (gap_last) begin
                    if (oor_hit)                state_d = ST_DONE;
                    else if (step_tap == tgt_q) state_d = ST_DONE;
                    else                        state_d = ST_MOVE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode; only the addressed lane's bits can assert.
    always_comb begin
        cal_ack = 1'b0;
        cal_err = 1'b0;
        dl_load = '0;
        dl_move = '0;
        dl_dir  = '0;
        case (state_q)
            ST_LOAD: dl_load = lane_oh;
            ST_SETUP, ST_GAP: dl_dir = (step_inc == DIR_INC) ? lane_oh : '0;
            ST_MOVE: begin
                dl_move = lane_oh;
                dl_dir  = (step_inc == DIR_INC) ? lane_oh : '0;
            end
            ST_DONE: begin
                cal_ack = 1'b1;
                cal_err = err_q;
            end
            default: ;
        endcase
    end

    // Engine control: error flag, gap counter, known bits (cleared on reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            gap_q   <= '0;
            known_q <= '0;
        end else begin
            if (req_acc)
                err_q <= ~req_in_range;
            else if (state_q == ST_GAP && gap_last && oor_hit)
                err_q <= 1'b1;
            gap_q <= (state_q == ST_GAP) ? gap_q + GAP_W'(1) : '0;
            if (state_q == ST_LOAD)
                known_q <= known_q | lane_oh;
        end
    end

    // Request capture: lane and target held for the whole walk.
    always_ff @(posedge clk) begin
        if (req_acc) begin
            lane_q <= cal_lane;
            tgt_q  <= cal_tap;
        end
    end

    // Tap table; contents are meaningful only while the known bit is set.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD)
            tap_q[lane_q] <= LOAD_TAP_V;
        else if (state_q == ST_GAP && gap_last && !oor_hit)
            tap_q[lane_q] <= step_tap;
    end

endmodule

// File: rtl/pf_ddr_ca_lane_ctrl.sv
// DDR address/command lane controller: registers 4:1 command beats onto the
// IOD TX/OE slots, parks idle lanes on their last level, and hosts the
// per-lane delay-line step engine.
module pf_ddr_ca_lane_ctrl
    import pf_ddr_ca_pkg::*;
#(
    parameter int NUM_LANES = 15,
    parameter int RATIO     = 4,
    parameter int TAP_W     = 8,
    parameter int LOAD_TAP  = 1,
    parameter int MOVE_GAP  = 3
) (
    input  logic                               FAB_CLK,
    input  logic                               ARST_N,
    input  logic                               OE_EN,
    input  logic                               CMD_VALID,
    output logic                               CMD_READY,
    input  logic [NUM_LANES*RATIO-1:0]         CMD_DATA,
    output logic [NUM_LANES*RATIO-1:0]         TX_DATA,
    output logic [NUM_LANES*RATIO-1:0]         OE_DATA,
    input  logic                               CAL_REQ,
    input  logic [lane_idx_w(NUM_LANES)-1:0]   CAL_LANE,
    input  logic [TAP_W-1:0]                   CAL_TAP,
    output logic                               CAL_ACK,
    output logic                               CAL_ERR,
    output logic [TAP_W-1:0]                   TAP_RD,
    output logic [NUM_LANES-1:0]               DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]               DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]               DELAY_LINE_DIRECTION,
    input  logic [NUM_LANES-1:0]               DELAY_LINE_OUT_OF_RANGE
);

    localparam int BUS_W = NUM_LANES * RATIO;

    logic [BUS_W-1:0] tx_p0;
    logic             oe_p0;
    logic             rst_done_q, req_acc_q;
    logic             eng_idle, eng_req_acc, beat_acc;

    // Every slot of a lane takes that lane's last-on-wire slot.
    function automatic logic [BUS_W-1:0] park_beat(input logic [BUS_W-1:0] beat);
        logic [BUS_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_LANES; i++)
            p[i*RATIO +: RATIO] = {RATIO{beat[i*RATIO + RATIO - 1]}};
        return p;
    endfunction

    // rst_done_q keeps READY low while reset is held even though the engine idles.
    assign CMD_READY = rst_done_q & eng_idle & ~req_acc_q;
    assign beat_acc  = CMD_VALID & CMD_READY;
    assign TX_DATA   = tx_p0;
    assign OE_DATA   = {BUS_W{oe_p0}};

    // Stage p0: beat/park register, OE register and READY gating flags.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            tx_p0      <= '0;
            oe_p0      <= 1'b0;
            rst_done_q <= 1'b0;
            req_acc_q  <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            req_acc_q  <= eng_req_acc;
            oe_p0      <= OE_EN;
            tx_p0      <= beat_acc ? CMD_DATA : park_beat(tx_p0);
        end
    end

    pf_ddr_dly_step_fsm #(
        .NUM_LANES (NUM_LANES),
        .TAP_W     (TAP_W),
        .LOAD_TAP  (LOAD_TAP),
        .MOVE_GAP  (MOVE_GAP)
    ) u_step (
        .clk      (FAB_CLK),
        .rst_n    (ARST_N),
        .cal_req  (CAL_REQ),
        .cal_lane (CAL_LANE),
        .cal_tap  (CAL_TAP),
        .cal_ack  (CAL_ACK),
        .cal_err  (CAL_ERR),
        .tap_rd   (TAP_RD),
        .dl_load  (DELAY_LINE_LOAD),
        .dl_move  (DELAY_LINE_MOVE),
        .dl_dir   (DELAY_LINE_DIRECTION),
        .dl_oor   (DELAY_LINE_OUT_OF_RANGE),
        .idle     (eng_idle),
        .req_acc  (eng_req_acc)
    );

endmodule

// File: tb/tb_pf_ddr_ca_lane_ctrl.sv
// Directed bench for pf_ddr_ca_lane_ctrl: beat/park data path, tap walks up
// and down, IOD range abort, bad lane, shared-cycle request, and mid-walk reset.
`timescale 1ns/1ps
module tb_pf_ddr_ca_lane_ctrl;

    localparam int NL = 15;
    localparam int R  = 4;
    localparam int TW = 8;
    localparam int LW = 4;

    localparam logic [NL*R-1:0] BEAT0 = 60'h00000000000785A;
    localparam logic [NL*R-1:0] PARK0 = 60'h000000000000F0F;
    localparam logic [NL*R-1:0] BEAT1 = 60'h123456789ABCDEF;

    logic             FAB_CLK = 1'b0;
    logic             ARST_N = 1'b0;
    logic             OE_EN = 1'b0;
    logic             CMD_VALID = 1'b0;
    logic             CMD_READY;
    logic [NL*R-1:0]  CMD_DATA = '0;
    logic [NL*R-1:0]  TX_DATA;
    logic [NL*R-1:0]  OE_DATA;
    logic             CAL_REQ = 1'b0;
    logic [LW-1:0]    CAL_LANE = '0;
    logic [TW-1:0]    CAL_TAP = '0;
    logic             CAL_ACK;
    logic             CAL_ERR;
    logic [TW-1:0]    TAP_RD;
    logic [NL-1:0]    DELAY_LINE_LOAD;
    logic [NL-1:0]    DELAY_LINE_MOVE;
    logic [NL-1:0]    DELAY_LINE_DIRECTION;
    logic [NL-1:0]    DELAY_LINE_OUT_OF_RANGE = '0;

    int checks = 0;
    int errors = 0;

    pf_ddr_ca_lane_ctrl #(
        .NUM_LANES (NL),
        .RATIO     (R),
        .TAP_W     (TW),
        .LOAD_TAP  (1),
        .MOVE_GAP  (3)
    ) dut (
        .FAB_CLK                 (FAB_CLK),
        .ARST_N                  (ARST_N),
        .OE_EN                   (OE_EN),
        .CMD_VALID               (CMD_VALID),
        .CMD_READY               (CMD_READY),
        .CMD_DATA                (CMD_DATA),
        .TX_DATA                 (TX_DATA),
        .OE_DATA                 (OE_DATA),
        .CAL_REQ                 (CAL_REQ),
        .CAL_LANE                (CAL_LANE),
        .CAL_TAP                 (CAL_TAP),
        .CAL_ACK                 (CAL_ACK),
        .CAL_ERR                 (CAL_ERR),
        .TAP_RD                  (TAP_RD),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge FAB_CLK);
        #1;
    endtask

    // Issues one request and watches cycles n=1.. until CAL_ACK (bounded).
    task automatic run_cal(input logic [LW-1:0] lane, input logic [TW-1:0] tap,
                           input int oor_after,
                           output int load_cnt, output int move_cnt,
                           output int first_mv, output int last_mv,
                           output logic dir_mv, output int ack_n,
                           output logic err, output logic stray,
                           output logic rdy_hi, output logic [NL*R-1:0] tx_first);
        logic [NL-1:0] mask;
        mask = NL'(1) << lane;
        load_cnt = 0; move_cnt = 0; first_mv = -1; last_mv = -1;
        dir_mv = 1'b0; ack_n = -1; err = 1'b0; stray = 1'b0; rdy_hi = 1'b0;
        CAL_LANE = lane;
        CAL_TAP  = tap;
        CAL_REQ  = 1'b1;
        tick;
        CAL_REQ   = 1'b0;
        CMD_VALID = 1'b0;
        tx_first  = TX_DATA;
        for (int n = 1; n <= 100; n++) begin
            if (|DELAY_LINE_LOAD) load_cnt++;
            if (|((DELAY_LINE_LOAD | DELAY_LINE_MOVE | DELAY_LINE_DIRECTION) & ~mask)) stray = 1'b1;
            if (CMD_READY) rdy_hi = 1'b1;
            if (|DELAY_LINE_MOVE) begin
                move_cnt++;
                if (first_mv < 0) first_mv = n;
                last_mv = n;
                dir_mv = |(DELAY_LINE_DIRECTION & mask);
                if (move_cnt == oor_after) DELAY_LINE_OUT_OF_RANGE = mask;
            end
            if (CAL_ACK) begin
                ack_n = n;
                err = CAL_ERR;
                break;
            end
            tick;
        end
        DELAY_LINE_OUT_OF_RANGE = '0;
    endtask

    int lc, mc, fm, lm, an, acks;
    logic dm, er, st, rh;
    logic [NL*R-1:0] tf;

    initial begin
        // Reset values
        repeat (2) @(posedge FAB_CLK);
        #2;
        check_val("rst_tx", TX_DATA, 0);
        check_val("rst_oe", OE_DATA, 0);
        check_val("rst_ready", CMD_READY, 0);
        check_val("rst_ack", {CAL_ACK, CAL_ERR}, 0);
        check_val("rst_pulses", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION}, 0);
        ARST_N = 1'b1;
        tick;
        check_val("ready_after_rst", CMD_READY, 1);

        // Beat then park
        OE_EN = 1'b1;
        CMD_VALID = 1'b1;
        CMD_DATA = BEAT0;
        tick;
        check_val("tx_beat", TX_DATA, BEAT0);
        check_val("oe_on", OE_DATA, {NL*R{1'b1}});
        CMD_VALID = 1'b0;
        tick;
        check_val("tx_park", TX_DATA, PARK0);
        tick;
        check_val("tx_park_hold", TX_DATA, PARK0);

        // Lane 3 unknown -> 4
        run_cal(3, 4, 0, lc, mc, fm, lm, dm, an, er, st, rh, tf);
        check_val("c1_load", lc, 1);
        check_val("c1_moves", mc, 3);
        check_val("c1_first_mv", fm, 3);
        check_val("c1_last_mv", lm, 11);
        check_val("c1_dir", dm, 1);
        check_val("c1_ack_n", an, 15);
        check_val("c1_err", er, 0);
        check_val("c1_stray", st, 0);
        check_val("c1_ready_low", rh, 0);
        tick;
        check_val("c1_ready_post", CMD_READY, 1);
        check_val("c1_tap", TAP_RD, 4);
        check_val("c1_tx_parked", TX_DATA, PARK0);

        // Lane 3 known, 4 -> 2
        run_cal(3, 2, 0, lc, mc, fm, lm, dm, an, er, st, rh, tf);
        check_val("c2_load", lc, 0);
        check_val("c2_moves", mc, 2);
        check_val("c2_first_mv", fm, 2);
        check_val("c2_last_mv", lm, 6);
        check_val("c2_dir", dm, 0);
        check_val("c2_ack_n", an, 10);
        check_val("c2_err", er, 0);
        check_val("c2_stray", st, 0);
        tick;
        check_val("c2_tap", TAP_RD, 2);

        // Lane 5 toward 10, IOD range flag after second move
        run_cal(5, 10, 2, lc, mc, fm, lm, dm, an, er, st, rh, tf);
        check_val("c3_load", lc, 1);
        check_val("c3_moves", mc, 2);
        check_val("c3_ack_n", an, 11);
        check_val("c3_err", er, 1);
        check_val("c3_stray", st, 0);
        tick;
        check_val("c3_tap", TAP_RD, 2);

        // Lane number beyond the bank
        run_cal(15, 0, 0, lc, mc, fm, lm, dm, an, er, st, rh, tf);
        check_val("c4_ack_n", an, 1);
        check_val("c4_err", er, 1);
        check_val("c4_pulses", lc + mc, 0);
        check_val("c4_stray", st, 0);
        tick;
        check_val("c4_ready_post", CMD_READY, 1);

        // Beat and request in the same cycle, lane 3: 2 -> 3
        OE_EN = 1'b0;
        CMD_VALID = 1'b1;
        CMD_DATA = BEAT1;
        run_cal(3, 3, 0, lc, mc, fm, lm, dm, an, er, st, rh, tf);
        check_val("c5_tx_beat", tf, BEAT1);
        check_val("c5_moves", mc, 1);
        check_val("c5_dir", dm, 1);
        check_val("c5_ack_n", an, 6);
        check_val("c5_ready_low", rh, 0);
        check_val("c5_oe_off", OE_DATA, 0);
        tick;
        check_val("c5_ready_post", CMD_READY, 1);
        check_val("c5_tap", TAP_RD, 3);

        // Reset while lane 7 sits in its first gap
        CAL_LANE = 7;
        CAL_TAP = 5;
        CAL_REQ = 1'b1;
        tick;
        CAL_REQ = 1'b0;
        tick;
        tick;
        check_val("c6_move", DELAY_LINE_MOVE, 15'h0080);
        tick;
        check_val("c6_gap_dir", DELAY_LINE_DIRECTION, 15'h0080);
        #2;
        ARST_N = 1'b0;
        #1;
        check_val("c6_rst_pulses", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION}, 0);
        check_val("c6_rst_data", {TX_DATA, OE_DATA}, 0);
        check_val("c6_rst_ready", CMD_READY, 0);
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            if (CAL_ACK) acks++;
            tick;
        end
        check_val("c6_no_ack", acks, 0);
        ARST_N = 1'b1;
        tick;
        run_cal(7, 2, 0, lc, mc, fm, lm, dm, an, er, st, rh, tf);
        check_val("c6_reload", lc, 1);
        check_val("c6_moves", mc, 1);
        check_val("c6_ack_n", an, 7);
        check_val("c6_err", er, 0);
        tick;
        check_val("c6_tap", TAP_RD, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
